// File: rtl/reverse_scanner_if.sv
// Bus between the reversi board and the reverse scanner: scan request, board read port and flip stream.
interface reverse_scanner_if;
    localparam int unsigned CW = 3;
    localparam int unsigned AW = 6;

    logic          start;
    logic [CW-1:0] place_x;
    logic [CW-1:0] place_y;
    logic          is_black;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data;
    logic          flip_valid;
    logic [AW-1:0] flip_addr;
    logic          busy;
    logic          done;
    logic [AW-1:0] flip_count;

    modport master (
        output start, place_x, place_y, is_black, rd_data,
        input  rd_addr, flip_valid, flip_addr, busy, done, flip_count
    );

    modport slave (
        input  start, place_x, place_y, is_black, rd_data,
        output rd_addr, flip_valid, flip_addr, busy, done, flip_count
    );
endinterface

// File: rtl/reverse_scanner.sv
// Walks the 8 directions from a placed piece on an 8x8 board and streams the addresses
// of opponent pieces bracketed by an own piece.
module reverse_scanner (
    input  logic              clk,
    input  logic              resetn,
    reverse_scanner_if.slave  bus
);
    localparam int unsigned CW = 3;
    localparam int unsigned AW = 6;
    localparam logic [CW-1:0] BLACK = 3'b111;
    localparam logic [CW-1:0] WHITE = 3'b110;

    typedef enum logic [2:0] {IDLE, DIR_INIT, READ, EVAL, FLIP, NEXT_DIR, FINISH} state_t;

    state_t        state, n_state;
    logic [2:0]    px, py, cx, cy, dir, run_len;
    logic [2:0]    n_px, n_py, n_cx, n_cy, n_dir, n_run_len;
    logic          black, n_black;
    logic [AW-1:0] rd_addr, n_rd_addr, flip_addr, n_flip_addr, flip_count, n_flip_count;
    logic          flip_valid, n_flip_valid, busy, n_busy, done, n_done;
    logic [6:0]    from_place, from_cur;
    logic [CW-1:0] own, opp;

    // One step in direction d; result is {off_board, y, x}. A 4-bit add exposes wrap in bit 3.
    function automatic logic [6:0] step(input logic [2:0] x, input logic [2:0] y, input logic [2:0] d);
        logic [3:0] dx, dy, nx, ny;
        dx = 4'd0;
        dy = 4'd0;
        case (d)
            3'd0: begin dx = 4'd0;  dy = 4'hF; end
            3'd1: begin dx = 4'd1;  dy = 4'hF; end
            3'd2: begin dx = 4'd1;  dy = 4'd0; end
            3'd3: begin dx = 4'd1;  dy = 4'd1; end
            3'd4: begin dx = 4'd0;  dy = 4'd1; end
            3'd5: begin dx = 4'hF;  dy = 4'd1; end
            3'd6: begin dx = 4'hF;  dy = 4'd0; end
            default: begin dx = 4'hF; dy = 4'hF; end
        endcase
        nx = {1'b0, x} + dx;
        ny = {1'b0, y} + dy;
        return {nx[3] | ny[3], ny[2:0], nx[2:0]};
    endfunction

    assign from_place = step(px, py, dir);
    assign from_cur   = step(cx, cy, dir);
    assign own        = black ? BLACK : WHITE;
    assign opp        = black ? WHITE : BLACK;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        n_state      = state;
        n_px         = px;
        n_py         = py;
        n_cx         = cx;
        n_cy         = cy;
        n_dir        = dir;
        n_run_len    = run_len;
        n_black      = black;
        n_rd_addr    = rd_addr;
        n_flip_addr  = flip_addr;
        n_flip_count = flip_count;
        n_busy       = busy;
        n_flip_valid = 1'b0;
        n_done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    n_px         = bus.place_x;
                    n_py         = bus.place_y;
                    n_black      = bus.is_black;
                    n_dir        = 3'd0;
                    n_flip_count = '0;
                    n_busy       = 1'b1;
                    n_state      = DIR_INIT;
                end
            end
            DIR_INIT: begin
                n_cx      = from_place[2:0];
                n_cy      = from_place[5:3];
                n_run_len = 3'd0;
                if (from_place[6]) begin
                    n_state = NEXT_DIR;
                end else begin
                    n_rd_addr = from_place[5:0];
                    n_state   = READ;
                end
            end
            READ: n_state = EVAL;
            EVAL: begin
                if (bus.rd_data == opp) begin
                    n_run_len = run_len + 3'd1;
                    n_cx      = from_cur[2:0];
                    n_cy      = from_cur[5:3];
                    if (from_cur[6]) begin
                        n_state = NEXT_DIR;
                    end else begin
                        n_rd_addr = from_cur[5:0];
                        n_state   = READ;
                    end
                end else if (bus.rd_data == own && run_len != 3'd0) begin
                    // First flip leaves with the transition so pulses line up with FLIP cycles.
                    n_flip_valid = 1'b1;
                    n_flip_addr  = from_place[5:0];
                    n_flip_count = flip_count + AW'(1);
                    n_cx         = from_place[2:0];
                    n_cy         = from_place[5:3];
                    n_run_len    = run_len - 3'd1;
                    n_state      = FLIP;
                end else begin
                    n_state = NEXT_DIR;
                end
            end
            FLIP: begin
                if (run_len == 3'd0) begin
                    n_state = NEXT_DIR;
                end else begin
                    n_flip_valid = 1'b1;
                    n_flip_addr  = from_cur[5:0];
                    n_flip_count = flip_count + AW'(1);
                    n_cx         = from_cur[2:0];
                    n_cy         = from_cur[5:3];
                    n_run_len    = run_len - 3'd1;
                end
            end
            NEXT_DIR: begin
                if (dir == 3'd7) begin
                    n_done  = 1'b1;
                    n_busy  = 1'b0;
                    n_state = FINISH;
                end else begin
                    n_dir   = dir + 3'd1;
                    n_state = DIR_INIT;
                end
            end
            FINISH:  n_state = IDLE;
            default: n_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            px         <= '0;
            py         <= '0;
            cx         <= '0;
            cy         <= '0;
            dir        <= '0;
            run_len    <= '0;
            black      <= 1'b0;
            rd_addr    <= '0;
            flip_addr  <= '0;
            flip_count <= '0;
            flip_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= n_state;
            px         <= n_px;
            py         <= n_py;
            cx         <= n_cx;
            cy         <= n_cy;
            dir        <= n_dir;
            run_len    <= n_run_len;
            black      <= n_black;
            rd_addr    <= n_rd_addr;
            flip_addr  <= n_flip_addr;
            flip_count <= n_flip_count;
            flip_valid <= n_flip_valid;
            busy       <= n_busy;
            done       <= n_done;
        end
    end

    assign bus.rd_addr    = rd_addr;
    assign bus.flip_valid = flip_valid;
    assign bus.flip_addr  = flip_addr;
    assign bus.flip_count = flip_count;
    assign bus.busy       = busy;
    assign bus.done       = done;
endmodule

// File: tb/tb_reverse_scanner.sv
// Scoreboard bench for reverse_scanner: a reference scan pushes expected flip addresses,
// the flip stream pops and compares them.
module tb_reverse_scanner;
    localparam logic [2:0] EMPTY  = 3'b000;
    localparam logic [2:0] ENABLE = 3'b100;
    localparam logic [2:0] BLACK  = 3'b111;
    localparam logic [2:0] WHITE  = 3'b110;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    reverse_scanner_if bif();
    reverse_scanner dut (.clk(clk), .resetn(resetn), .bus(bif));

    logic [2:0] board [64];
    always @(posedge clk) bif.rd_data <= board[bif.rd_addr];

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int exp_total = 0;
    int done_cnt = 0;
    int flip_cnt = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int cyc = 0;
    bit seen [64];
    int dxs [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dys [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Flip stream monitor: pop the scoreboard on every flip pulse.
    always @(negedge clk) begin
        if (resetn) begin
            if (bif.flip_valid) begin
                flip_cnt++;
                if (flip_cnt == 1) first_cyc = cyc;
                last_cyc = cyc;
                if (exp_q.size() > 0) check("flip_addr", 32'(bif.flip_addr), 32'(exp_q.pop_front()));
                else                  check("flip_extra", 32'(flip_cnt), 32'(exp_total));
            end
            if (bif.done) done_cnt++;
            if (bif.busy) seen[bif.rd_addr] = 1'b1;
        end
    end

    function automatic int model(input int px, input int py, input bit blk);
        logic [2:0] own, opp, c;
        int x, y, n, total;
        own = blk ? BLACK : WHITE;
        opp = blk ? WHITE : BLACK;
        total = 0;
        for (int d = 0; d < 8; d++) begin
            x = px + dxs[d];
            y = py + dys[d];
            n = 0;
            while (x >= 0 && x < 8 && y >= 0 && y < 8) begin
                c = board[y*8 + x];
                if (c == opp) begin
                    n++;
                    x += dxs[d];
                    y += dys[d];
                end else begin
                    if (c == own && n > 0) begin
                        for (int k = 1; k <= n; k++) exp_q.push_back((py + k*dys[d])*8 + px + k*dxs[d]);
                        total += n;
                    end
                    break;
                end
            end
        end
        return total;
    endfunction

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = EMPTY;
    endtask

    task automatic scan(input int px, input int py, input bit blk, input int exp_cnt, input bit stray);
        int m;
        int cnt;
        done_cnt = 0;
        flip_cnt = 0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        exp_q.delete();
        m = model(px, py, blk);
        exp_total = m;
        @(negedge clk);
        bif.start    = 1'b1;
        bif.place_x  = 3'(px);
        bif.place_y  = 3'(py);
        bif.is_black = blk;
        @(negedge clk);
        bif.start = 1'b0;
        check("busy_after_start", 32'(bif.busy), 32'd1);
        if (stray) begin
            repeat (3) @(negedge clk);
            bif.start    = 1'b1;
            bif.place_x  = 3'(7 - px);
            bif.place_y  = 3'(7 - py);
            bif.is_black = ~blk;
            @(negedge clk);
            bif.start = 1'b0;
        end
        cnt = 0;
        while (done_cnt == 0 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        repeat (3) @(negedge clk);
        check("done_once", 32'(done_cnt), 32'd1);
        check("busy_idle", 32'(bif.busy), 32'd0);
        check("flip_count_model", 32'(bif.flip_count), 32'(m));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (exp_cnt >= 0) check("flip_count_ref", 32'(bif.flip_count), 32'(exp_cnt));
    endtask

    initial begin
        int bad;
        int cnt;
        logic [2:0] codes [4];
        codes = '{EMPTY, ENABLE, BLACK, WHITE};
        bif.start    = 1'b0;
        bif.place_x  = '0;
        bif.place_y  = '0;
        bif.is_black = 1'b0;
        clear_board();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",       32'(bif.busy),       32'd0);
        check("rst_done",       32'(bif.done),       32'd0);
        check("rst_flip_valid", 32'(bif.flip_valid), 32'd0);
        check("rst_flip_addr",  32'(bif.flip_addr),  32'd0);
        check("rst_rd_addr",    32'(bif.rd_addr),    32'd0);
        check("rst_flip_count", 32'(bif.flip_count), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Corner, empty board: only cells 1, 8, 9 may be read
        scan(0, 0, 1'b0, 0, 1'b0);
        bad = 0;
        for (int a = 0; a < 64; a++)
            if (seen[a] && !(a == 0 || a == 1 || a == 8 || a == 9)) bad++;
        check("corner_bad_reads", 32'(bad), 32'd0);
        check("corner_reads_1_8_9", 32'(seen[1] & seen[8] & seen[9]), 32'd1);

        clear_board();
        board[27] = WHITE;
        board[35] = BLACK;
        scan(3, 2, 1'b1, 1, 1'b0);

        clear_board();
        for (int i = 1; i <= 6; i++) board[i] = WHITE;
        board[7] = BLACK;
        scan(0, 0, 1'b1, 6, 1'b0);
        check("long_run_consecutive", 32'(last_cyc - first_cyc), 32'd5);

        clear_board();
        for (int i = 1; i <= 3; i++) board[i] = WHITE;
        scan(0, 0, 1'b1, 0, 1'b0);

        clear_board();
        board[28] = WHITE;
        board[29] = BLACK;
        board[35] = WHITE;
        board[43] = BLACK;
        scan(3, 3, 1'b1, 2, 1'b0);
        scan(3, 3, 1'b1, 2, 1'b1);

        // Reset in the middle of a flip run
        clear_board();
        for (int i = 1; i <= 6; i++) board[i] = WHITE;
        board[7] = BLACK;
        done_cnt = 0;
        flip_cnt = 0;
        exp_q.delete();
        exp_total = model(0, 0, 1'b1);
        @(negedge clk);
        bif.start    = 1'b1;
        bif.place_x  = 3'd0;
        bif.place_y  = 3'd0;
        bif.is_black = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        cnt = 0;
        while (flip_cnt < 2 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        resetn = 1'b0;
        #1;
        check("rst_mid_flip_valid", 32'(bif.flip_valid), 32'd0);
        check("rst_mid_busy",       32'(bif.busy),       32'd0);
        check("rst_mid_flip_count", 32'(bif.flip_count), 32'd0);
        exp_q.delete();
        exp_total = flip_cnt;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        check("no_flip_after_reset", 32'(flip_cnt), 32'(exp_total));
        check("no_done_after_reset", 32'(done_cnt), 32'd0);
        scan(0, 0, 1'b1, 6, 1'b0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 64; i++) board[i] = codes[$urandom_range(3)];
            scan(int'($urandom_range(7)), int'($urandom_range(7)), 1'($urandom_range(1)), -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
